icdf_rr_scheduler: RTL and testbench
====================================

Name: icdf_rr_scheduler

Overview:
- Shares one inverse-CDF pipeline (u in [0,1) → z-score, in-order, valid/ready) among N_REQ Sobol-dimension requesters.
- Round-robin arbiter issues one u per cycle into a registered issue stage.
- A tag FIFO records the requester ID of every in-flight sample, and each returning z is routed to that requester.
- A credit counter caps in-flight samples so the tag FIFO never overflows. Sits between the Sobol generators and the path-generation step.

Parameters:
- N_REQ, 4, number of requesters (≥2)
- WIDTH, fpga_cfg_pkg::FP_WIDTH, fixed-point sample width
- MAX_INFLIGHT, 16, maximum samples issued and not yet retired; also tag FIFO depth (power of 2)
- ID_W, $clog2(N_REQ), requester tag width (derived)
- CNT_W, $clog2(MAX_INFLIGHT+1), in-flight counter width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester sample valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_u  in  N_REQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
- icdf_valid  out  1  to pipeline valid_in
- icdf_ready  in  1  from pipeline ready_out
- icdf_u  out  WIDTH  to pipeline u_in
- icdf_z_valid  in  1  pipeline valid_out
- icdf_z_ready  out  1  to pipeline ready_in
- icdf_z  in  WIDTH  pipeline z_out
- rsp_valid  out  N_REQ  per-requester result valid, one-hot or zero
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_z  out  WIDTH  result data, shared by all requesters
- inflight  out  CNT_W  current in-flight count
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge): icdf_valid=0, icdf_u=0, rr pointer=0, tag FIFO empty, inflight=0, err=0. All in-flight tags are discarded. The pipeline must be reset in the same cycle.
- Issue stage: icdf_valid/icdf_u are registers.
  - can_load = (!icdf_valid || icdf_ready) && (inflight < MAX_INFLIGHT).
  - When can_load, the arbiter grants the first requester with req_valid set, searching from rr pointer upward with wrap.
  - req_ready[g]=1 combinationally for the granted index g only. req_ready is all-zero when !can_load or no request.
- Grant handshake (req_valid[g] && req_ready[g]):
  - icdf_u <= req_u[g], icdf_valid <= 1.
  - Push g into the tag FIFO; inflight increments.
  - rr pointer <= (g+1) mod N_REQ. The pointer is unchanged when there is no grant.
- icdf_ready high with no grant that cycle: icdf_valid <= 0. If icdf_ready is low, icdf_u and icdf_valid hold.
- Issue latency: requester handshake at cycle k → icdf_valid=1 at cycle k+1.
- Fairness: with all requesters continuously valid and no backpressure, grants go 0,1,2,3,0,… one per cycle.
- Response path is combinational, with no added latency:
  - h = FIFO head tag, ne = FIFO not empty.
  - rsp_valid[h] = icdf_z_valid && ne. All other rsp_valid bits are 0.
  - rsp_z = icdf_z.
  - icdf_z_ready = ne && rsp_ready[h].
- Retire (icdf_z_valid && icdf_z_ready): pop the FIFO; inflight decrements.
- Grant and retire in the same cycle: inflight is unchanged, FIFO push and pop both occur, and the count is correct at MAX_INFLIGHT.
- Full: inflight==MAX_INFLIGHT blocks all grants. A same-cycle retire does not unblock (can_load uses the registered count).
- Protocol error: icdf_z_valid=1 while the FIFO is empty sets err=1 until reset. icdf_z_ready stays 0 and the FIFO is unaffected.
- inflight counts samples from the grant through retire, including the one held in the issue register.
- The pipeline is in-order, so no reordering logic is needed. Head tag order equals grant order.

Test Plan:
- Single requester 2, u=0x4000_0000 (0.5), rsp_ready=all 1, echo model with fixed latency 6 → grant one cycle, icdf_valid cycle k+1, rsp_valid=4'b0100 with model z, inflight back to 0.
- All four req_valid=1 for 8 cycles, icdf_ready=1 → req_ready sequence 0001,0010,0100,1000 repeating. Results return to rsp_valid in the same order.
- icdf_ready=0 for 5 cycles with requester 1 valid → icdf_valid/icdf_u hold the first sample, one grant only, inflight=1, req_ready=0 during the stall.
- MAX_INFLIGHT=16, model never asserts icdf_z_valid → exactly 16 grants, then req_ready=0. One retire gives exactly one further grant the next cycle.
- Response for requester 3 with rsp_ready[3]=0 for 3 cycles → icdf_z_ready=0 and the FIFO head holds. Release → retire, inflight decrements.
- Assert rst with 5 in flight → next cycle inflight=0, icdf_valid=0, err=0. A stray icdf_z_valid afterwards → err=1 and stays 1.

Source files
------------

// File: rtl/icdf_rr_scheduler.sv
// ----------------------------------------------------------------------------
// icdf_rr_scheduler
//   Lets N_REQ Sobol-dimension requesters share one in-order inverse-CDF
//   pipeline. A round-robin arbiter loads one u per cycle into a registered
//   issue stage. A tag FIFO remembers which requester owns each in-flight
//   sample, so every returning z is steered back to its owner. An in-flight
//   counter caps outstanding samples at MAX_INFLIGHT, which is also the tag
//   FIFO depth, so the FIFO can never overflow.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid/ready/u   per-requester sample request (ready is one-hot or zero)
//   icdf_valid/ready/u  issue stage towards the pipeline input
//   icdf_z_valid/ready/z pipeline output
//   rsp_valid/ready     per-requester result handshake (valid one-hot or zero)
//   rsp_z          result data, shared by all requesters
//   inflight       samples granted and not yet retired
//   err            sticky: pipeline produced a result with no tag outstanding
// ----------------------------------------------------------------------------
package fpga_cfg_pkg;
  parameter int FP_WIDTH = 32;
endpackage

module icdf_rr_scheduler #(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = fpga_cfg_pkg::FP_WIDTH,
  parameter int MAX_INFLIGHT = 16,
  parameter int ID_W         = $clog2(N_REQ),
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_u,
  output logic                   icdf_valid,
  input  logic                   icdf_ready,
  output logic [WIDTH-1:0]       icdf_u,
  input  logic                   icdf_z_valid,
  output logic                   icdf_z_ready,
  input  logic [WIDTH-1:0]       icdf_z,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_z,
  output logic [CNT_W-1:0]       inflight,
  output logic                   err
);

  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             can_load;
  logic             fire;
  logic             tags_ne;
  logic [ID_W-1:0]  head_tag;
  logic             retire;
  int               scan;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Search upward from the round-robin pointer, wrapping at N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!grant_found && req_valid[scan]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan);
      end
    end
  end

  // Registered count only: a retire in this cycle does not free a slot
  // until the next cycle.
  assign can_load = (!icdf_valid || icdf_ready) && (inflight < CNT_W'(MAX_INFLIGHT));
  assign fire     = can_load && grant_found;

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[grant_idx] = 1'b1;
  end

  // The FIFO holds exactly one tag per in-flight sample, so the count
  // doubles as the not-empty flag.
  assign tags_ne  = (inflight != '0);
  assign head_tag = tag_mem[rd_ptr];

  always_comb begin
    rsp_valid = '0;
    if (icdf_z_valid && tags_ne) rsp_valid[head_tag] = 1'b1;
  end

  assign icdf_z_ready = tags_ne && rsp_ready[head_tag];
  assign rsp_z        = icdf_z;
  assign retire       = icdf_z_valid && icdf_z_ready;

  always_ff @(posedge clk) begin
    if (fire) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icdf_valid <= 1'b0;
      icdf_u     <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      err        <= 1'b0;
    end else begin
      if (fire) begin
        icdf_u     <= req_u[int'(grant_idx)*WIDTH +: WIDTH];
        icdf_valid <= 1'b1;
        wr_ptr     <= ptr_inc(wr_ptr);
        rr_ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else if (icdf_ready) begin
        icdf_valid <= 1'b0;
      end

      if (retire) rd_ptr <= ptr_inc(rd_ptr);

      case ({fire, retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (icdf_z_valid && !tags_ne) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icdf_rr_scheduler.sv
module tb_icdf_rr_scheduler;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MAX = 16;
  localparam int CW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_u;
  logic           icdf_valid;
  logic           icdf_ready;
  logic [W-1:0]   icdf_u;
  logic           icdf_z_valid;
  logic           icdf_z_ready;
  logic [W-1:0]   icdf_z;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_z;
  logic [CW-1:0]  inflight;
  logic           err;

  icdf_rr_scheduler #(.N_REQ(N), .WIDTH(W), .MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_u(req_u),
    .icdf_valid(icdf_valid), .icdf_ready(icdf_ready), .icdf_u(icdf_u),
    .icdf_z_valid(icdf_z_valid), .icdf_z_ready(icdf_z_ready), .icdf_z(icdf_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: queue of owner IDs in grant order plus the issue slot.
  int         m_ptr;
  logic       m_iv;
  logic [W-1:0] m_iu;
  logic       m_err;
  int         tagq[$];

  // Echo pipeline stand-in: in-order, per-sample latency.
  typedef struct { logic [W-1:0] z; int due; } pent_t;
  pent_t      pq[$];
  int         cyc;
  int         lat_fix;
  logic       z_hold;
  logic       stray;

  int         glog[$];
  int         rlog[$];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic [W-1:0] fz(input logic [W-1:0] u);
    return {u[15:0], ~u[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pipe();
    logic head_ok;
    head_ok = (pq.size() > 0) && (pq[0].due <= cyc);
    icdf_z_valid = stray || (!z_hold && head_ok);
    icdf_z = (pq.size() > 0) ? pq[0].z : 32'hDEAD_BEEF;
  endtask

  task automatic step();
    int g, h, lat;
    logic can, ne, zr;
    logic [N-1:0] one, e_rr, e_rv;
    one = 1;
    drive_pipe();
    @(negedge clk);
    can = (!m_iv || icdf_ready) && (tagq.size() < MAX);
    g = -1;
    if (can) for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    e_rr = (g >= 0) ? (one << g) : '0;
    ne = tagq.size() > 0;
    h  = ne ? tagq[0] : 0;
    e_rv = (icdf_z_valid && ne) ? (one << h) : '0;
    zr = ne && rsp_ready[h];
    chk("req_ready", req_ready, e_rr);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("icdf_z_ready", icdf_z_ready, zr);
    chk("rsp_z", rsp_z, icdf_z);
    if (req_ready != '0) glog.push_back(oh2i(req_ready));
    if ((rsp_valid & rsp_ready) != '0) rlog.push_back(oh2i(rsp_valid));
    // pipeline consumes the issue slot as it stands before this edge
    if (m_iv && icdf_ready) begin
      lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, 8);
      pq.push_back('{fz(m_iu), cyc + lat});
    end
    if (icdf_z_valid && zr) begin
      if (pq.size() > 0) void'(pq.pop_front());
      void'(tagq.pop_front());
    end
    if (icdf_z_valid && !ne) m_err = 1'b1;
    if (g >= 0) begin
      m_iu  = req_u[g*W +: W];
      m_iv  = 1'b1;
      tagq.push_back(g);
      m_ptr = (g + 1) % N;
    end else if (icdf_ready) begin
      m_iv = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("icdf_valid", icdf_valid, m_iv);
    chk("icdf_u", icdf_u, m_iu);
    chk("inflight", inflight, tagq.size());
    chk("err", err, m_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    icdf_z_valid = 1'b0;
    stray = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    m_ptr = 0; m_iv = 1'b0; m_iu = '0; m_err = 1'b0;
    tagq.delete(); pq.delete(); glog.delete(); rlog.delete();
    chk("rst_icdf_valid", icdf_valid, 1'b0);
    chk("rst_icdf_u", icdf_u, '0);
    chk("rst_inflight", inflight, '0);
    chk("rst_err", err, 1'b0);
  endtask

  task automatic set_u(input int i, input logic [W-1:0] v);
    req_u[i*W +: W] = v;
  endtask

  initial begin
    cyc = 0; lat_fix = 0; z_hold = 1'b0; stray = 1'b0;
    rst = 1'b1; req_valid = '0; req_u = '0; icdf_ready = 1'b1;
    icdf_z_valid = 1'b0; icdf_z = '0; rsp_ready = '1;
    #1;
    do_reset();

    // single requester 2, fixed latency 6
    lat_fix = 6;
    set_u(2, 32'h4000_0000);
    req_valid = 4'b0100;
    step();
    chk("t1_icdf_u", icdf_u, 32'h4000_0000);
    req_valid = '0;
    for (int i = 0; i < 20 && tagq.size() > 0; i++) step();
    chk("t1_inflight", inflight, 0);
    chk("t1_rsp_cnt", rlog.size(), 1);
    if (rlog.size() > 0) chk("t1_rsp_idx", rlog[0], 2);

    // all four requesting, no backpressure
    do_reset();
    lat_fix = 3;
    for (int i = 0; i < N; i++) set_u(i, $urandom);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    req_valid = '0;
    for (int i = 0; i < 16 && tagq.size() > 0; i++) step();
    chk("t2_ngrant", glog.size(), 8);
    chk("t2_nrsp", rlog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("t2_grant_order", glog[i], i % 4);
    for (int i = 0; i < 8 && i < rlog.size(); i++) chk("t2_rsp_order", rlog[i], i % 4);

    // issue stall
    do_reset();
    set_u(1, 32'h1234_5678);
    icdf_ready = 1'b0;
    req_valid = 4'b0010;
    for (int i = 0; i < 6; i++) step();
    chk("t3_ngrant", glog.size(), 1);
    chk("t3_inflight", inflight, 1);
    chk("t3_icdf_u", icdf_u, 32'h1234_5678);
    chk("t3_icdf_valid", icdf_valid, 1'b1);
    icdf_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 16 && tagq.size() > 0; i++) step();
    chk("t3_drain", inflight, 0);

    // credit limit
    do_reset();
    lat_fix = 1;
    z_hold = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) step();
    chk("t4_ngrant", glog.size(), 16);
    chk("t4_inflight", inflight, 16);
    chk("t4_req_ready", req_ready, '0);
    z_hold = 1'b0;
    step();
    chk("t4_after_retire", inflight, 15);
    z_hold = 1'b1;
    glog.delete();
    for (int i = 0; i < 3; i++) step();
    chk("t4_one_more", glog.size(), 1);
    chk("t4_full_again", inflight, 16);
    z_hold = 1'b0;
    req_valid = '0;

    // result backpressure on requester 3
    do_reset();
    lat_fix = 2;
    set_u(3, 32'hCAFE_0003);
    rsp_ready = 4'b0111;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    for (int i = 0; i < 7; i++) step();
    chk("t5_z_valid", icdf_z_valid, 1'b1);
    chk("t5_z_ready", icdf_z_ready, 1'b0);
    chk("t5_rsp_valid", rsp_valid, 4'b1000);
    chk("t5_hold", inflight, 1);
    rsp_ready = '1;
    step();
    chk("t5_release", inflight, 0);

    // reset with samples in flight, then a stray result
    do_reset();
    z_hold = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    req_valid = '0;
    step();
    chk("t6_inflight", inflight, 5);
    do_reset();
    z_hold = 1'b0;
    stray = 1'b1;
    step();
    stray = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t6_err_sticky", err, 1'b1);

    // randomized traffic
    do_reset();
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++) set_u(r, $urandom);
      icdf_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = N'($urandom | $urandom);
      z_hold = ($urandom_range(0, 7) == 0);
      step();
    end
    req_valid = '0;
    icdf_ready = 1'b1;
    rsp_ready = '1;
    z_hold = 1'b0;
    for (int i = 0; i < 200 && tagq.size() > 0; i++) step();
    chk("rand_drain", inflight, 0);
    chk("rand_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
